fetch_stage: RTL

//  Stage 1 of the 2-stage core. Holds the PC and issues single-outstanding reads
//  to instruction memory. Registers the returned instruction plus its PC for stage 2.

---
 rtl/fetch_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: stage 1 of the 2-stage core.
// Holds the PC, issues one instruction-memory read at a time, and registers
// the returned instruction with its PC for stage 2. A one-entry skid buffer
// catches a response that arrives while stage 2 is stalled. Taken control
// transfers from stage 2 redirect the PC and squash any in-flight fetch.
module fetch_stage #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_valid,
  output logic [4:0]      opcode,
  output logic [PC_W-1:0] link_pc
);

  // BOOT  : one idle cycle after reset release
  // ISSUE : read request is on the bus this cycle
  // WAIT  : request outstanding, waiting for the response
  // HOLD  : response parked in the skid buffer until stage 2 can take it
  // KILL  : request outstanding but squashed by a redirect; drop its data
  typedef enum logic [2:0] {BOOT, ISSUE, WAIT, HOLD, KILL} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            imem_req_q, imem_req_d;
  logic [PC_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] instr_pc_q, instr_pc_d;
  logic            instr_valid_q, instr_valid_d;
  logic [31:0]     skid_q, skid_d;

  logic            takeRedirect;
  logic [PC_W-1:0] pcInc;

  // A redirect only counts when it comes from a real, unstalled instruction.
  assign takeRedirect = redirect & instr_valid_q & ~stall;
  assign pcInc        = pc_q + PC_W'(1);

  // Next-state logic: sequential fetch, then redirect overrides on top.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    skid_d        = skid_q;
    instr_valid_d = stall ? instr_valid_q : 1'b0;

    case (state_q)
      BOOT: state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (imem_valid) begin
          if (stall) begin
            skid_d  = imem_rdata;
            state_d = HOLD;
          end else begin
            instr_d       = imem_rdata;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pcInc;
            state_d       = ISSUE;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          instr_d       = skid_q;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pcInc;
          skid_d        = '0;
          state_d       = ISSUE;
        end
      end
      KILL: begin
        if (imem_valid) begin
          state_d = ISSUE;
        end
      end
      default: state_d = BOOT;
    endcase

    if (takeRedirect) begin
      pc_d          = redirect_pc;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = 1'b0;
      skid_d        = '0;
      case (state_q)
        WAIT:        state_d = imem_valid ? ISSUE : KILL;
        ISSUE, KILL: state_d = KILL;
        default:     state_d = ISSUE;
      endcase
    end

    imem_req_d  = (state_d == ISSUE);
    imem_addr_d = imem_req_d ? pc_d : imem_addr_q;
  end

  // State and registered outputs; the request is high exactly while in ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      skid_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      skid_q        <= skid_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign opcode      = instr_q[31:27];
  assign link_pc     = instr_pc_q + PC_W'(1);

endmodule
